// File: rtl/time_entry.sv
// time_entry: front-panel min/sec preset editor feeding the countdown timer.
// Define TIME_ENTRY_AUTOREPEAT_EN to enable hold-to-repeat on up/down.
module time_entry #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int QUICK_ADD_SEC = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       btn_quick,
  input  logic       btn_clear,
  input  logic       busy,
  input  logic       done,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic       field,
  output logic       start_req,
  output logic       locked
);
  typedef enum logic {EDIT, LOCKED} state_t;
  state_t state;
  logic [4:0] btns, s, h, ev;
  logic rep_up, rep_dn, step_up, step_dn;
  logic [6:0] q_sum, q_min, q_min_f, q_sec_f, nmin, nsec;
  logic q_carry, q_sat, nfield, nstart;
  assign btns = {btn_clear, btn_quick, btn_sel, btn_down, btn_up};
  assign ev = (state == EDIT) ? (s & ~h) : '0;
  // simultaneous up and down (press or repeat) cancel each other
  assign step_up = (ev[0] | rep_up) & ~(ev[1] | rep_dn);
  assign step_dn = (ev[1] | rep_dn) & ~(ev[0] | rep_up);
  // quick add is below one minute, so at most one carry into minutes
  assign q_sum   = sec + 7'(QUICK_ADD_SEC);
  assign q_carry = q_sum >= 7'd60;
  assign q_min   = min + {6'd0, q_carry};
  assign q_sat   = q_min > 7'd99;
  assign q_min_f = q_sat ? 7'd99 : q_min;
  assign q_sec_f = q_sat ? 7'd59 : (q_carry ? q_sum - 7'd60 : q_sum);
`ifdef TIME_ENTRY_AUTOREPEAT_EN
  logic [31:0] cnt_up, cnt_dn;
  logic held_up, held_dn;
  function automatic logic fire(input logic [31:0] c);
    return (c + 32'd1 == 32'(REPEAT_DELAY)) || (c + 32'd1 == 32'(REPEAT_DELAY + REPEAT_PERIOD));
  endfunction
  function automatic logic [31:0] advance(input logic held, input logic [31:0] c);
    return !held ? 32'd0 : (c + 32'd1 == 32'(REPEAT_DELAY + REPEAT_PERIOD)) ? 32'(REPEAT_DELAY) : c + 32'd1;
  endfunction
  assign held_up = (state == EDIT) & s[0] & ~s[1];
  assign held_dn = (state == EDIT) & s[1] & ~s[0];
  assign rep_up  = held_up & fire(cnt_up);
  assign rep_dn  = held_dn & fire(cnt_dn);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_up <= '0;
      cnt_dn <= '0;
    end else begin
      cnt_up <= advance(held_up, cnt_up);
      cnt_dn <= advance(held_dn, cnt_dn);
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY == REPEAT_PERIOD);
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif
  always_comb begin
    nmin   = min;
    nsec   = sec;
    nfield = field;
    nstart = 1'b0;
    if (done || ev[4]) begin
      nmin   = '0;
      nsec   = '0;
      nfield = 1'b0;
    end else if (ev[3]) begin
      nmin   = q_min_f;
      nsec   = q_sec_f;
      nstart = (q_min_f != 7'd0) || (q_sec_f != 7'd0);
    end else if (step_up && field) begin
      nmin = (min < 7'd99) ? min + 7'd1 : min;
    end else if (step_up) begin
      nsec = (sec < 7'd59) ? sec + 7'd1 : (min < 7'd99) ? 7'd0 : sec;
      nmin = (sec == 7'd59 && min < 7'd99) ? min + 7'd1 : min;
    end else if (step_dn && field) begin
      nmin = (min > 7'd0) ? min - 7'd1 : min;
    end else if (step_dn) begin
      nsec = (sec > 7'd0) ? sec - 7'd1 : (min > 7'd0) ? 7'd59 : sec;
      nmin = (sec == 7'd0 && min > 7'd0) ? min - 7'd1 : min;
    end else if (ev[2]) begin
      nfield = ~field;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= EDIT;
      s         <= '0;
      h         <= '0;
      min       <= '0;
      sec       <= '0;
      field     <= 1'b0;
      start_req <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= busy ? LOCKED : EDIT;
      locked    <= busy;
      s         <= btns;
      h         <= s;
      min       <= nmin;
      sec       <= nsec;
      field     <= nfield;
      start_req <= nstart;
    end
  end
endmodule

// File: tb/tb_time_entry.sv
// tb_time_entry: directed scoreboard bench for time_entry.
module tb_time_entry;
  logic clock = 1'b0, reset = 1'b1, busy = 1'b0, done = 1'b0;
  logic [4:0] btns = '0;
  logic [6:0] min, sec;
  logic field, start_req, locked;
  logic [16:0] obs;
  int checks = 0, errors = 0;
  typedef struct {string tag; logic [16:0] v;} exp_t;
  exp_t sb[$];

  time_entry #(.REPEAT_DELAY(10), .REPEAT_PERIOD(4), .QUICK_ADD_SEC(30)) dut (
    .clock(clock), .reset(reset),
    .btn_up(btns[0]), .btn_down(btns[1]), .btn_sel(btns[2]), .btn_quick(btns[3]), .btn_clear(btns[4]),
    .busy(busy), .done(done),
    .min(min), .sec(sec), .field(field), .start_req(start_req), .locked(locked)
  );

  always #5 clock = ~clock;
  assign obs = {min, sec, field, start_req, locked};

  task automatic push(input string tag, input int m, input int s, input bit f, input bit st, input bit lk);
    exp_t e;
    e.tag = tag;
    e.v = {7'(m), 7'(s), f, st, lk};
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s got min=%0d sec=%0d fld=%0b st=%0b lk=%0b want min=%0d sec=%0d fld=%0b st=%0b lk=%0b",
             e.tag, obs[16:10], obs[9:3], obs[2], obs[1], obs[0],
             e.v[16:10], e.v[9:3], e.v[2], e.v[1], e.v[0]);
    end
  endtask

  task automatic press(input logic [4:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      btns = mask;
      @(negedge clock);
      btns = '0;
      @(negedge clock);
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    push("reset", 0, 0, 0, 0, 0); pop_check();
    for (int i = 1; i <= 3; i++) begin
      press(5'b00001, 1);
      push("up_step", 0, i, 0, 0, 0); pop_check();
    end
    press(5'b00001, 56);
    push("to_00_59", 0, 59, 0, 0, 0); pop_check();
    press(5'b00001, 1);
    push("carry_up", 1, 0, 0, 0, 0); pop_check();
    press(5'b00010, 1);
    push("borrow_down", 0, 59, 0, 0, 0); pop_check();
    press(5'b10000, 1);
    push("clear", 0, 0, 0, 0, 0); pop_check();
    press(5'b00010, 1);
    push("down_floor", 0, 0, 0, 0, 0); pop_check();
    press(5'b00100, 1);
    push("sel_min", 0, 0, 1, 0, 0); pop_check();
    press(5'b00001, 99);
    push("min_99", 99, 0, 1, 0, 0); pop_check();
    press(5'b00001, 1);
    push("min_sat", 99, 0, 1, 0, 0); pop_check();
    press(5'b00100, 1);
    press(5'b00001, 45);
    push("pre_quick", 99, 45, 0, 0, 0); pop_check();
    press(5'b01000, 1);
    push("quick_sat", 99, 59, 0, 1, 0); pop_check();
    @(negedge clock);
    push("start_one_cycle", 99, 59, 0, 0, 0); pop_check();
    press(5'b10000, 1);
    press(5'b00100, 1);
    press(5'b00001, 1);
    press(5'b00100, 1);
    press(5'b00001, 40);
    push("pre_01_40", 1, 40, 0, 0, 0); pop_check();
    press(5'b01000, 1);
    push("quick_carry", 2, 10, 0, 1, 0); pop_check();
    busy = 1'b1;
    @(negedge clock);
    push("lock", 2, 10, 0, 0, 1); pop_check();
    press(5'b00001, 1);
    press(5'b10000, 1);
    press(5'b01000, 1);
    push("lock_ignore", 2, 10, 0, 0, 1); pop_check();
    done = 1'b1;
    @(negedge clock);
    push("done_locked", 0, 0, 0, 0, 1); pop_check();
    done = 1'b0;
    busy = 1'b0;
    @(negedge clock);
    push("unlock", 0, 0, 0, 0, 0); pop_check();
    press(5'b00001, 1);
    push("after_unlock", 0, 1, 0, 0, 0); pop_check();
    btns = 5'b00001;
    @(negedge clock);
    btns = '0;
    busy = 1'b1;
    @(negedge clock);
    push("busy_edge_honored", 0, 2, 0, 0, 1); pop_check();
    busy = 1'b0;
    repeat (2) @(negedge clock);
    press(5'b00011, 1);
    push("up_down_cancel", 0, 2, 0, 0, 0); pop_check();
    btns = 5'b00001;
    @(negedge clock);
    btns = '0;
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    push("done_wins", 0, 0, 0, 0, 0); pop_check();
    press(5'b01000, 1);
    push("quick_basic", 0, 30, 0, 1, 0); pop_check();
    btns = 5'b01000;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    push("async_reset", 0, 0, 0, 0, 0); pop_check();
    @(negedge clock);
    btns = '0;
    reset = 1'b0;
    @(negedge clock);
    btns = 5'b00001;
    repeat (30) @(negedge clock);
    btns = '0;
    repeat (3) @(negedge clock);
`ifdef TIME_ENTRY_AUTOREPEAT_EN
    push("hold_repeat", 0, 7, 0, 0, 0); pop_check();
`else
    push("hold_single", 0, 1, 0, 0, 0); pop_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/time_entry.md
# time_entry

Operator time-entry controller for the microwave. Turns the front-panel up/down/select/quick/clear buttons into the `min`/`sec` preset that the countdown timer loads. It also issues a one-cycle start request for the quick-add key. The block sits between the button inputs and the timer. It locks its value while the timer reports busy, and it clears the preset when the timer reports done.

## Interface
Parameters:
- `REPEAT_DELAY`, default 50_000_000: cycles a held up/down button must stay high before auto-repeat begins.
- `REPEAT_PERIOD`, default 10_000_000: cycles between auto-repeat steps once repeating.
- `QUICK_ADD_SEC`, default 30: seconds added by the quick key, range 1..59.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `btn_up` in 1: increment selected field, level input.
- `btn_down` in 1: decrement selected field, level input.
- `btn_sel` in 1: toggle selected field between seconds and minutes.
- `btn_quick` in 1: add `QUICK_ADD_SEC` and request start.
- `btn_clear` in 1: clear preset to 00:00.
- `busy` in 1: timer running or paused, level.
- `done` in 1: timer finished, one-cycle pulse.
- `min` out 7: preset minutes, 0..99.
- `sec` out 7: preset seconds, 0..59.
- `field` out 1: selected field; 0 = seconds, 1 = minutes.
- `start_req` out 1: one-cycle pulse requesting timer start.
- `locked` out 1: high in state LOCKED.

## Operation
- Each button passes through one synchronizer flop (`s`) and one history flop (`h`). A press event is `s & ~h`.
- States:
  - EDIT: buttons modify the preset.
  - LOCKED: all button events ignored, auto-repeat counters held at 0.
- State transitions:
  - EDIT→LOCKED when `busy`=1.
  - LOCKED→EDIT when `busy`=0.
  - `done`=1 in any state forces `min`=0, `sec`=0, `field`=0. The state is still decided by `busy`.
- Event priority in EDIT, one action per cycle: clear > quick > up/down > sel.
  - If up and down press events occur in the same cycle, both are discarded.
- Clear: `min`=0, `sec`=0, `field`=0.
- Quick: total = min*60+sec+`QUICK_ADD_SEC`, saturating at 99:59.
  - Result re-split into min/sec.
  - `start_req` pulses in the same cycle the new value registers.
- Up, field=sec:
  - sec<59: sec+1.
  - sec=59 and min<99: sec=0, min+1.
  - At 99:59: no change.
- Down, field=sec:
  - sec>0: sec−1.
  - sec=0 and min>0: sec=59, min−1.
  - At 00:00: no change.
- Up, field=min: min+1 if min<99, else no change.
- Down, field=min: min−1 if min>0, else no change.
- Sel: `field` toggles.
- `done` coincident with a button event: `done` wins and the event is dropped.
- `start_req` is never asserted in LOCKED, or when the quick result would be 00:00.

## Timing
- Reset values:
  - `min`=0, `sec`=0, `field`=0, `start_req`=0, `locked`=0.
  - State EDIT; sync/history flops 0; repeat counters 0.
- Button latency: button first sampled high at edge N; `s` goes high at N, press event valid during cycle N→N+1, output updated after edge N+1.
- `locked` follows `busy` with 1 cycle latency. Button events in the cycle `busy` is first seen high are still honored.
- `done` takes effect at the first edge it is sampled high.
- Auto-repeat, when enabled:
  - The repeat counter counts while the synchronized up (or down) is held and the other is low.
  - At count `REPEAT_DELAY` a step fires; thereafter a step fires every `REPEAT_PERIOD` cycles.
  - The counter clears on release or on entering LOCKED.
- Reset mid-operation clears everything immediately and drops any pending `start_req`.

## Configuration
- `TIME_ENTRY_AUTOREPEAT_EN` defined: holding up/down auto-repeats per the Timing rules; counters present.
- Undefined: exactly one step per press regardless of hold duration; repeat counters and parameters unused.

## Test plan
- Reset, then 3 `btn_up` presses with field=sec → `min`=0, `sec`=3; `start_req` never high.
- Preset 00:59, field=sec, `btn_up` → 01:00. Then `btn_down` → 00:59. At 00:00, `btn_down` → stays 00:00.
- `btn_sel` then `btn_up` at min=99 → stays 99. Quick at 99:45 → 99:59, `start_req` one cycle.
- Quick from 01:40 → 02:10 and one `start_req` pulse. Then `busy`=1: `locked`=1 next cycle; up/clear presses leave 02:10.
- `done` pulse while LOCKED with 02:10 → 00:00, field=0. `busy`=0 → `locked`=0; next `btn_up` → 00:01.
- With `TIME_ENTRY_AUTOREPEAT_EN`, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=4, field=sec:
  - Hold `btn_up` 30 cycles from 00:00 → 1 press step + steps at hold cycles 10,14,18,22,26,30 → 00:07.
  - Without the macro → 00:01.
